banked_regfile: RTL and testbench

- Mode-aware ARM register file; next-generation replacement for the flat 37-entry register bank.
- Translates logical r0–r15 to physical banked registers using CPSR mode bits.
- Provides NUM_RD combinational read ports, one synchronous GPR write port, a dedicated PC port, and masked CPSR/SPSR access.
- Adds a hardware exception-entry sequencer (two-cycle) and a one-cycle exception return; sits between decode and execute.

---
 rtl/banked_regfile.sv | 151 +++++++++++++++
 tb/tb_banked_regfile.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/banked_regfile.sv
// rtl/banked_regfile.sv - mode-aware banked ARM register file with exception entry/return (optional RF_BYPASS_EN)
module banked_regfile #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_RD     = 2,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [4:0]        RESET_MODE = 5'b10011
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_wdata,
  output logic [DATA_W-1:0]        pc,
  input  logic                     cpsr_we,
  input  logic [31:0]              cpsr_wdata,
  input  logic [31:0]              cpsr_mask,
  input  logic                     spsr_we,
  input  logic [31:0]              spsr_wdata,
  output logic [31:0]              cpsr,
  output logic [31:0]              spsr,
  input  logic                     exc_req,
  input  logic [4:0]               exc_mode,
  input  logic [DATA_W-1:0]        exc_vector,
  input  logic [DATA_W-1:0]        exc_ret_addr,
  input  logic                     exc_ret,
  output logic                     busy
);

  typedef enum logic {S_IDLE, S_SWITCH} state_t;

  // Bank id: 0 user set (usr/sys/invalid), 1 fiq, 2 irq, 3 svc, 4 abt, 5 und.
  function automatic logic [2:0] f_bank(input logic [4:0] m);
    case (m)
      5'b10001: return 3'd1;
      5'b10010: return 3'd2;
      5'b10011: return 3'd3;
      5'b10111: return 3'd4;
      5'b11011: return 3'd5;
      default:  return 3'd0;
    endcase
  endfunction

  // Physical layout: 0..14 user r0-r14, 15..21 fiq r8-r14, 22..29 r13/r14 of irq/svc/abt/und.
  // Address 15 is never looked up here; PC lives in its own register.
  function automatic logic [4:0] f_phys(input logic [2:0] b, input logic [3:0] a);
    if (b == 3'd1 && a >= 4'd8)
      return 5'd7 + {1'b0, a};
    else if (b >= 3'd2 && a >= 4'd13)
      return 5'd18 + {1'b0, b, 1'b0} + {1'b0, a} - 5'd13;
    else
      return {1'b0, a};
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_gpr [0:29];
  logic [DATA_W-1:0] r_pc;
  logic [31:0]       r_cpsr;
  logic [31:0]       r_spsr [1:5];
  logic [4:0]        r_lmode;
  logic [DATA_W-1:0] r_lvec;

  logic [2:0]        w_cur_bank;
  logic [2:0]        w_exc_bank;
  logic [4:0]        w_wr_idx;
  logic [4:0]        w_exc_lr_idx;
  logic [31:0]       w_cur_spsr;

  assign w_cur_bank   = f_bank(r_cpsr[4:0]);
  assign w_exc_bank   = f_bank(exc_mode);
  assign w_wr_idx     = f_phys(w_cur_bank, wr_addr);
  assign w_exc_lr_idx = f_phys(w_exc_bank, 4'd14);
  assign w_cur_spsr   = (w_cur_bank == 3'd0) ? 32'h0 : r_spsr[w_cur_bank];

  assign pc   = r_pc;
  assign cpsr = r_cpsr;
  assign spsr = w_cur_spsr;
  assign busy = (r_state == S_SWITCH);

  // Exception sequencer state register.
  always_ff @(posedge clk1) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Exception sequencer next state: IDLE -> SWITCH on a request, SWITCH always lasts one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (exc_req) w_state_nxt = S_SWITCH;
      S_SWITCH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Architectural state update: reset, mode switch, exception save, or normal writes.
  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < 30; i++) r_gpr[i] <= '0;
      for (int i = 1; i <= 5; i++) r_spsr[i] <= '0;
      r_pc    <= RESET_PC;
      r_cpsr  <= {24'h0, 3'b110, RESET_MODE};
      r_lmode <= '0;
      r_lvec  <= '0;
    end else if (r_state == S_SWITCH) begin
      r_cpsr[4:0] <= r_lmode;
      r_cpsr[7]   <= 1'b1;
      if (f_bank(r_lmode) == 3'd1) r_cpsr[6] <= 1'b1;
      r_cpsr[5]   <= 1'b0;
      r_pc        <= r_lvec;
    end else if (exc_req) begin
      // Entry edge: save state into the target mode; ordinary writes are dropped.
      if (w_exc_bank != 3'd0) r_spsr[w_exc_bank] <= r_cpsr;
      r_gpr[w_exc_lr_idx] <= exc_ret_addr;
      r_lmode             <= exc_mode;
      r_lvec              <= exc_vector;
    end else begin
      // GPR index is resolved with the pre-edge mode even if cpsr_we changes it now.
      if (wr_en && wr_addr != 4'd15) r_gpr[w_wr_idx] <= wr_data;
      if (pc_we)                         r_pc <= pc_wdata;
      else if (wr_en && wr_addr == 4'd15) r_pc <= wr_data;
      if (exc_ret && w_cur_bank != 3'd0) r_cpsr <= w_cur_spsr;
      else if (cpsr_we)                  r_cpsr <= (r_cpsr & ~cpsr_mask) | (cpsr_wdata & cpsr_mask);
      if (spsr_we && w_cur_bank != 3'd0) r_spsr[w_cur_bank] <= spsr_wdata;
    end
  end

  // Combinational read ports through the current mode, with optional same-cycle write forwarding.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[4*k +: 4] == 4'd15)
        rd_data[DATA_W*k +: DATA_W] = r_pc;
      else
        rd_data[DATA_W*k +: DATA_W] = r_gpr[f_phys(w_cur_bank, rd_addr[4*k +: 4])];
`ifdef RF_BYPASS_EN
      if (rd_addr[4*k +: 4] == 4'd15) begin
        if (pc_we && !busy) rd_data[DATA_W*k +: DATA_W] = pc_wdata;
      end else if (wr_en && !busy && wr_addr != 4'd15 &&
                   f_phys(w_cur_bank, rd_addr[4*k +: 4]) == w_wr_idx) begin
        rd_data[DATA_W*k +: DATA_W] = wr_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_banked_regfile.sv
// tb/tb_banked_regfile.sv - self-checking bench for banked_regfile with a mode-view reference model
module tb_banked_regfile;
  localparam int DW = 32;
  localparam int NR = 2;

  logic            clk1 = 1'b0;
  logic            rst;
  logic [4*NR-1:0] rd_addr;
  logic [DW*NR-1:0] rd_data;
  logic            wr_en;
  logic [3:0]      wr_addr;
  logic [DW-1:0]   wr_data;
  logic            pc_we;
  logic [DW-1:0]   pc_wdata;
  logic [DW-1:0]   pc;
  logic            cpsr_we;
  logic [31:0]     cpsr_wdata;
  logic [31:0]     cpsr_mask;
  logic            spsr_we;
  logic [31:0]     spsr_wdata;
  logic [31:0]     cpsr;
  logic [31:0]     spsr;
  logic            exc_req;
  logic [4:0]      exc_mode;
  logic [DW-1:0]   exc_vector;
  logic [DW-1:0]   exc_ret_addr;
  logic            exc_ret;
  logic            busy;

  banked_regfile #(.DATA_W(DW), .NUM_RD(NR), .RESET_PC('0), .RESET_MODE(5'b10011)) dut (
    .clk1(clk1), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_we(pc_we), .pc_wdata(pc_wdata), .pc(pc),
    .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata), .cpsr_mask(cpsr_mask),
    .spsr_we(spsr_we), .spsr_wdata(spsr_wdata), .cpsr(cpsr), .spsr(spsr),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_ret_addr(exc_ret_addr), .exc_ret(exc_ret), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  logic [4:0] modes [0:7] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                              5'b10111, 5'b11011, 5'b11111, 5'b00101};

  // Reference model: one array per register view the architecture defines.
  logic [31:0] m_usr [0:14];
  logic [31:0] m_fiq [0:6];
  logic [31:0] m_bnk [0:3][0:1];
  logic [31:0] m_spsr [0:4];
  logic [31:0] m_pc, m_cpsr, m_lvec;
  logic [4:0]  m_lmode;
  bit          m_busy;

  function automatic int mode_sel(input logic [4:0] m);
    case (m)
      5'b10001: return 1;
      5'b10010: return 2;
      5'b10011: return 3;
      5'b10111: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] mode, input int a);
    int s;
    s = mode_sel(mode);
    if (a == 15) return m_pc;
    if (s == 1 && a >= 8) return m_fiq[a-8];
    if (s >= 2 && a >= 13) return m_bnk[s-2][a-13];
    return m_usr[a];
  endfunction

  function automatic logic [31:0] m_spsr_view();
    int s;
    s = mode_sel(m_cpsr[4:0]);
    return (s == 0) ? 32'h0 : m_spsr[s-1];
  endfunction

  task automatic m_write(input logic [4:0] mode, input int a, input logic [31:0] d);
    int s;
    s = mode_sel(mode);
    if (a == 15) m_pc = d;
    else if (s == 1 && a >= 8) m_fiq[a-8] = d;
    else if (s >= 2 && a >= 13) m_bnk[s-2][a-13] = d;
    else m_usr[a] = d;
  endtask

  task automatic model_step();
    logic [31:0] old;
    int s, t;
    old = m_cpsr;
    s = mode_sel(old[4:0]);
    if (rst) begin
      foreach (m_usr[i]) m_usr[i] = 0;
      foreach (m_fiq[i]) m_fiq[i] = 0;
      foreach (m_bnk[i, j]) m_bnk[i][j] = 0;
      foreach (m_spsr[i]) m_spsr[i] = 0;
      m_pc = 0; m_cpsr = 32'hD3; m_busy = 0;
    end else if (m_busy) begin
      m_cpsr[4:0] = m_lmode;
      m_cpsr[7] = 1'b1;
      if (mode_sel(m_lmode) == 1) m_cpsr[6] = 1'b1;
      m_cpsr[5] = 1'b0;
      m_pc = m_lvec;
      m_busy = 0;
    end else if (exc_req) begin
      t = mode_sel(exc_mode);
      if (t != 0) m_spsr[t-1] = old;
      m_write(exc_mode, 14, exc_ret_addr);
      m_lmode = exc_mode; m_lvec = exc_vector; m_busy = 1;
    end else begin
      if (wr_en) m_write(old[4:0], int'(wr_addr), wr_data);
      if (pc_we) m_pc = pc_wdata;
      if (exc_ret && s != 0) m_cpsr = m_spsr[s-1];
      else if (cpsr_we) m_cpsr = (old & ~cpsr_mask) | (cpsr_wdata & cpsr_mask);
      if (spsr_we && s != 0) m_spsr[s-1] = spsr_wdata;
    end
  endtask

  task automatic clr();
    rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; pc_we = 0; pc_wdata = 0;
    cpsr_we = 0; cpsr_wdata = 0; cpsr_mask = 0; spsr_we = 0; spsr_wdata = 0;
    exc_req = 0; exc_mode = 0; exc_vector = 0; exc_ret_addr = 0; exc_ret = 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk1);
    #1;
    clr();
    #1;
  endtask

  task automatic set_mode(input logic [4:0] m);
    cpsr_we = 1; cpsr_mask = 32'h1F; cpsr_wdata = {27'h0, m};
    cycle();
  endtask

  task automatic test_reset();
    clr(); rst = 1; rd_addr = {4'd14, 4'd0};
    cycle();
    checks++; if (cpsr !== 32'hD3) begin errors++; $display("FAIL reset_cpsr got %h exp %h", cpsr, 32'hD3); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (spsr !== 32'h0) begin errors++; $display("FAIL reset_spsr got %h exp 0", spsr); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd got %h exp 0", rd_data); end
  endtask

  task automatic test_banking();
    rd_addr = {4'd0, 4'd13};
    wr_en = 1; wr_addr = 13; wr_data = 32'h1111; cycle();
    set_mode(5'b10000);
    wr_en = 1; wr_addr = 13; wr_data = 32'h2222; cycle();
    checks++; if (rd_data[31:0] !== 32'h2222) begin errors++; $display("FAIL usr_r13 got %h exp %h", rd_data[31:0], 32'h2222); end
    checks++; if (spsr !== 32'h0) begin errors++; $display("FAIL usr_spsr got %h exp 0", spsr); end
    set_mode(5'b10011);
    checks++; if (rd_data[31:0] !== 32'h1111) begin errors++; $display("FAIL svc_r13 got %h exp %h", rd_data[31:0], 32'h1111); end
  endtask

  task automatic test_fiq_entry();
    set_mode(5'b10000);
    wr_en = 1; wr_addr = 8; wr_data = 32'hA; cycle();
    wr_en = 1; wr_addr = 0; wr_data = 32'h77; cycle();
    exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C; exc_ret_addr = 32'h100;
    wr_en = 1; wr_addr = 1; wr_data = 32'hBAD;
    cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL entry_busy got %b exp 1", busy); end
    wr_en = 1; wr_addr = 0; wr_data = 32'hDEAD; pc_we = 1; pc_wdata = 32'h999;
    spsr_we = 1; spsr_wdata = 32'h5; exc_ret = 1;
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL entry_done got %b exp 0", busy); end
    checks++; if (cpsr !== 32'hD1) begin errors++; $display("FAIL fiq_cpsr got %h exp %h", cpsr, 32'hD1); end
    checks++; if (pc !== 32'h1C) begin errors++; $display("FAIL fiq_pc got %h exp %h", pc, 32'h1C); end
    checks++; if (spsr !== 32'hD0) begin errors++; $display("FAIL fiq_spsr got %h exp %h", spsr, 32'hD0); end
    rd_addr = {4'd8, 4'd14};
    #1;
    checks++; if (rd_data[31:0] !== 32'h100) begin errors++; $display("FAIL fiq_lr got %h exp %h", rd_data[31:0], 32'h100); end
    checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL fiq_r8 got %h exp 0", rd_data[63:32]); end
    rd_addr = {4'd1, 4'd0};
    #1;
    checks++; if (rd_data[31:0] !== 32'h77) begin errors++; $display("FAIL shared_r0 got %h exp %h", rd_data[31:0], 32'h77); end
    checks++; if (rd_data[63:32] !== 32'h0) begin errors++; $display("FAIL dropped_r1 got %h exp 0", rd_data[63:32]); end
  endtask

  task automatic test_exc_ret();
    rd_addr = {4'd0, 4'd8};
    exc_ret = 1; cycle();
    checks++; if (cpsr !== 32'hD0) begin errors++; $display("FAIL ret_cpsr got %h exp %h", cpsr, 32'hD0); end
    checks++; if (rd_data[31:0] !== 32'hA) begin errors++; $display("FAIL ret_r8 got %h exp %h", rd_data[31:0], 32'hA); end
    exc_ret = 1; cycle();
    checks++; if (cpsr !== 32'hD0) begin errors++; $display("FAIL ret_usr got %h exp %h", cpsr, 32'hD0); end
  endtask

  task automatic test_same_edge_mode();
    rd_addr = {4'd0, 4'd13};
    wr_en = 1; wr_addr = 13; wr_data = 32'h3333;
    cpsr_we = 1; cpsr_mask = 32'h1F; cpsr_wdata = 32'h13;
    cycle();
    checks++; if (rd_data[31:0] !== 32'h1111) begin errors++; $display("FAIL svc_r13_kept got %h exp %h", rd_data[31:0], 32'h1111); end
    set_mode(5'b10000);
    checks++; if (rd_data[31:0] !== 32'h3333) begin errors++; $display("FAIL usr_r13_new got %h exp %h", rd_data[31:0], 32'h3333); end
  endtask

  task automatic test_precedence();
    rd_addr = {4'd0, 4'd15};
    wr_en = 1; wr_addr = 15; wr_data = 32'h40; pc_we = 1; pc_wdata = 32'h80; cycle();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL pc_prio got %h exp %h", pc, 32'h80); end
    wr_en = 1; wr_addr = 15; wr_data = 32'h40; cycle();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL wr_pc got %h exp %h", pc, 32'h40); end
    checks++; if (rd_data[31:0] !== 32'h40) begin errors++; $display("FAIL rd15 got %h exp %h", rd_data[31:0], 32'h40); end
  endtask

  task automatic test_bypass();
    logic [31:0] e1, e0;
    rd_addr = {4'd3, 4'd15};
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; pc_we = 1; pc_wdata = 32'h1234;
    #1;
`ifdef RF_BYPASS_EN
    e1 = 32'h55; e0 = 32'h1234;
`else
    e1 = m_read(m_cpsr[4:0], 3); e0 = m_pc;
`endif
    checks++; if (rd_data[63:32] !== e1) begin errors++; $display("FAIL bypass_r3 got %h exp %h", rd_data[63:32], e1); end
    checks++; if (rd_data[31:0] !== e0) begin errors++; $display("FAIL bypass_pc got %h exp %h", rd_data[31:0], e0); end
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL pc_no_bypass got %h exp %h", pc, m_pc); end
    cycle();
    checks++; if (rd_data[63:32] !== 32'h55) begin errors++; $display("FAIL r3_written got %h exp %h", rd_data[63:32], 32'h55); end
  endtask

  task automatic test_reset_in_switch();
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18; exc_ret_addr = 32'h44; cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL irq_busy got %b exp 1", busy); end
    rst = 1; cycle();
    cycle();
    checks++; if (cpsr !== 32'hD3) begin errors++; $display("FAIL rst_sw_cpsr got %h exp %h", cpsr, 32'hD3); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_sw_pc got %h exp 0", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_sw_busy got %b exp 0", busy); end
  endtask

  task automatic test_random();
    logic [31:0] exp_v;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      wr_en = $urandom_range(0, 1); wr_addr = 4'($urandom_range(0, 15)); wr_data = $urandom;
      pc_we = ($urandom_range(0, 3) == 0); pc_wdata = $urandom;
      cpsr_we = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) begin
        cpsr_mask = 32'h1F; cpsr_wdata = {27'h0, modes[$urandom_range(0, 7)]};
      end else begin
        cpsr_mask = $urandom; cpsr_wdata = $urandom;
      end
      spsr_we = ($urandom_range(0, 3) == 0); spsr_wdata = $urandom;
      exc_req = ($urandom_range(0, 7) == 0); exc_mode = modes[$urandom_range(0, 7)];
      exc_vector = $urandom; exc_ret_addr = $urandom;
      exc_ret = ($urandom_range(0, 7) == 0);
      rd_addr = 8'($urandom);
      cycle();
      checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h exp %h", n, pc, m_pc); end
      checks++; if (cpsr !== m_cpsr) begin errors++; $display("FAIL rnd_cpsr n=%0d got %h exp %h", n, cpsr, m_cpsr); end
      exp_v = m_spsr_view();
      checks++; if (spsr !== exp_v) begin errors++; $display("FAIL rnd_spsr n=%0d got %h exp %h", n, spsr, exp_v); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %b exp %b", n, busy, m_busy); end
      for (int k = 0; k < NR; k++) begin
        exp_v = m_read(m_cpsr[4:0], int'(rd_addr[4*k +: 4]));
        checks++;
        if (rd_data[DW*k +: DW] !== exp_v) begin
          errors++; $display("FAIL rnd_rd%0d n=%0d addr %0d got %h exp %h", k, n, rd_addr[4*k +: 4], rd_data[DW*k +: DW], exp_v);
        end
      end
    end
  endtask

  initial begin
    clr();
    rst = 1;
    rd_addr = '0;
    test_reset();
    test_banking();
    test_fiq_entry();
    test_exc_ret();
    test_same_edge_mode();
    test_precedence();
    test_bypass();
    test_reset_in_switch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
